// File: rtl/mem_seq_ctrl_if.sv
// Bundles the datapath request/result signals and the data memory port of mem_seq_ctrl.
// The slave modport is the sequencer's view; master is the CPU datapath plus memory.
interface mem_seq_ctrl_if #(
    parameter int unsigned ADR_W  = 10,
    parameter int unsigned DATA_W = 16
);
    logic              start;
    logic              op;
    logic [ADR_W-1:0]  base_adr;
    logic [ADR_W-1:0]  count;
    logic [ADR_W-1:0]  dst_adr;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] result;
    logic              ovf;
    logic [ADR_W-1:0]  mem_adr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_wen;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output start, op, base_adr, count, dst_adr, mem_rdata,
        input  busy, done, result, ovf, mem_adr, mem_wdata, mem_wen
    );

    modport slave (
        input  start, op, base_adr, count, dst_adr, mem_rdata,
        output busy, done, result, ovf, mem_adr, mem_wdata, mem_wen
    );
endinterface

// File: rtl/mem_seq_ctrl.sv
// Block-reduction sequencer: reads COUNT words from BASE, sums or takes the unsigned max,
// writes the result to DST, then pulses done and holds result/ovf until the next accept.
module mem_seq_ctrl #(
    parameter int unsigned ADR_W  = 10,
    parameter int unsigned DATA_W = 16
) (
    input logic           clk,
    input logic           rst_n,
    mem_seq_ctrl_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

    state_t            state_q, state_d;
    logic              op_q, op_d;
    logic [ADR_W-1:0]  base_q, base_d;
    logic [ADR_W-1:0]  cnt_q, cnt_d;
    logic [ADR_W-1:0]  dst_q, dst_d;
    logic [ADR_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic              ovf_q, ovf_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [DATA_W:0]   sum_w;

    logic [ADR_W-1:0]  mem_adr_w;
    logic [DATA_W-1:0] mem_wdata_w;
    logic              mem_wen_w;
    logic              done_w;

    // Extra top bit captures the carry-out that feeds the sticky overflow flag.
    assign sum_w = {1'b0, acc_q} + {1'b0, bus.mem_rdata};

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        base_d      = base_q;
        cnt_d       = cnt_q;
        dst_d       = dst_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        result_d    = result_q;
        mem_adr_w   = '0;
        mem_wdata_w = '0;
        mem_wen_w   = 1'b0;
        done_w      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    op_d    = bus.op;
                    base_d  = bus.base_adr;
                    cnt_d   = bus.count;
                    dst_d   = bus.dst_adr;
                    idx_d   = '0;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = (bus.count != '0) ? S_READ : S_WRITE;
                end
            end
            S_READ: begin
                mem_adr_w = base_q + idx_q;
                if (op_q) begin
                    acc_d = (bus.mem_rdata > acc_q) ? bus.mem_rdata : acc_q;
                end else begin
                    acc_d = sum_w[DATA_W-1:0];
                    ovf_d = ovf_q | sum_w[DATA_W];
                end
                idx_d = idx_q + ADR_W'(1);
                if (idx_q == cnt_q - ADR_W'(1)) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                mem_adr_w   = dst_q;
                mem_wdata_w = acc_q;
                mem_wen_w   = 1'b1;
                result_d    = acc_q;
                state_d     = S_DONE;
            end
            S_DONE: begin
                done_w  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= 1'b0;
            base_q   <= '0;
            cnt_q    <= '0;
            dst_q    <= '0;
            idx_q    <= '0;
            acc_q    <= '0;
            ovf_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            base_q   <= base_d;
            cnt_q    <= cnt_d;
            dst_q    <= dst_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            ovf_q    <= ovf_d;
            result_q <= result_d;
        end
    end

    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = done_w;
    assign bus.result    = result_q;
    assign bus.ovf       = ovf_q;
    assign bus.mem_adr   = mem_adr_w;
    assign bus.mem_wdata = mem_wdata_w;
    assign bus.mem_wen   = mem_wen_w;
endmodule

// File: tb/tb_mem_seq_ctrl.sv
// Self-checking bench for mem_seq_ctrl: behavioural memory plus a plain-arithmetic
// reduction model evaluated on the memory contents before each operation.
module tb_mem_seq_ctrl;
    localparam int unsigned AW    = 10;
    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 1024;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_seq_ctrl_if #(.ADR_W(AW), .DATA_W(DW)) bus ();
    mem_seq_ctrl #(.ADR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [DW-1:0] mem [DEPTH];
    assign bus.mem_rdata = mem[bus.mem_adr];
    always @(posedge clk) if (bus.mem_wen) mem[bus.mem_adr] <= bus.mem_wdata;

    int checks = 0;
    int errors = 0;

    int            obs_reads, obs_writes, obs_lat, obs_wdata_bad;
    logic [AW-1:0] obs_wadr;
    logic [DW-1:0] obs_wdata;
    bit            obs_timeout, obs_busy_after;
    int            adr_q[$];

    function automatic void model(input bit op, input int base, input int cnt,
                                  output logic [DW-1:0] res, output bit ov);
        longint total = 0;
        int mx = 0;
        for (int i = 0; i < cnt; i++) begin
            int v = int'(mem[(base + i) % DEPTH]);
            total += v;
            if (v > mx) mx = v;
        end
        if (op) begin
            res = DW'(mx);
            ov  = 1'b0;
        end else begin
            res = DW'(total % 65536);
            ov  = (total > 65535);
        end
    endfunction

    // Runs one operation and records what the DUT did; nag keeps start asserted while busy.
    task automatic do_op(input bit op, input int base, input int cnt, input int dst, input bit nag);
        bit seen = 0;
        adr_q.delete();
        obs_reads = 0; obs_writes = 0; obs_lat = -1; obs_wdata_bad = 0;
        obs_timeout = 0; obs_wadr = '0; obs_wdata = '0;
        @(negedge clk);
        bus.start = 1'b1; bus.op = op;
        bus.base_adr = AW'(base); bus.count = AW'(cnt); bus.dst_adr = AW'(dst);
        @(posedge clk);
        #1;
        if (!nag) bus.start = 1'b0;
        bus.op       = ~op;
        bus.base_adr = AW'($urandom);
        bus.count    = AW'($urandom_range(1, 20));
        bus.dst_adr  = AW'((dst + 10) % DEPTH);
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (bus.mem_wen) begin
                obs_writes++; obs_wadr = bus.mem_adr; obs_wdata = bus.mem_wdata;
            end else if (bus.mem_wdata !== '0) begin
                obs_wdata_bad++;
            end
            if (bus.done === 1'b1) begin
                obs_lat = k + 1; bus.start = 1'b0; seen = 1; break;
            end
            if (bus.busy === 1'b1 && bus.mem_wen === 1'b0) begin
                obs_reads++; adr_q.push_back(int'(bus.mem_adr));
            end
        end
        obs_timeout = !seen;
        @(negedge clk);
        obs_busy_after = bus.busy | bus.done;
    endtask

    task automatic test_reset();
        bus.start = 0; bus.op = 0; bus.base_adr = '0; bus.count = '0; bus.dst_adr = '0;
        rst_n = 1'b0;
        #12;
        checks++;
        if ({bus.busy, bus.done, bus.mem_wen, bus.ovf} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags got=%b exp=0000", {bus.busy, bus.done, bus.mem_wen, bus.ovf});
        end
        checks++;
        if (bus.result !== '0 || bus.mem_adr !== '0 || bus.mem_wdata !== '0) begin
            errors++; $display("FAIL reset_values result=%h adr=%h wdata=%h exp=0", bus.result, bus.mem_adr, bus.mem_wdata);
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_sum_basic();
        logic [DW-1:0] er; bit eo;
        for (int i = 0; i < 10; i++) mem[100 + i] = DW'(i + 1);
        mem[200] = 16'hA5A5;
        model(0, 100, 10, er, eo);
        do_op(0, 100, 10, 200, 0);
        checks++;
        if (obs_timeout || obs_lat != 12) begin
            errors++; $display("FAIL sum_latency got=%0d exp=12 timeout=%0d", obs_lat, obs_timeout);
        end
        checks++;
        if (obs_reads != 10) begin errors++; $display("FAIL sum_reads got=%0d exp=10", obs_reads); end
        checks++;
        if (bus.result !== er || er !== 16'd55 || bus.ovf !== eo) begin
            errors++; $display("FAIL sum_result got=%0d/%0b exp=%0d/%0b", bus.result, bus.ovf, er, eo);
        end
        checks++;
        if (mem[200] !== er || obs_writes != 1 || obs_wadr !== AW'(200)) begin
            errors++; $display("FAIL sum_write mem=%0d writes=%0d adr=%0d exp=%0d/1/200", mem[200], obs_writes, obs_wadr, er);
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (i >= adr_q.size() || adr_q[i] != 100 + i) begin
                errors++; $display("FAIL sum_addr idx=%0d got=%0d exp=%0d", i, (i < adr_q.size()) ? adr_q[i] : -1, 100 + i);
            end
        end
        checks++;
        if (obs_wdata_bad != 0 || obs_busy_after) begin
            errors++; $display("FAIL sum_idle wdata_bad=%0d busy_after=%0b exp=0/0", obs_wdata_bad, obs_busy_after);
        end
    endtask

    task automatic test_max_basic();
        logic [DW-1:0] er; bit eo;
        model(1, 100, 10, er, eo);
        do_op(1, 100, 10, 201, 0);
        checks++;
        if (obs_timeout || bus.result !== er || er !== 16'd10 || bus.ovf !== 1'b0 || mem[201] !== er) begin
            errors++; $display("FAIL max_result got=%0d ovf=%0b mem=%0d exp=%0d ovf=0", bus.result, bus.ovf, mem[201], er);
        end
    endtask

    task automatic test_overflow();
        logic [DW-1:0] er; bit eo;
        mem[300] = 16'hFFFF; mem[301] = 16'h0002;
        model(0, 300, 2, er, eo);
        do_op(0, 300, 2, 302, 0);
        checks++;
        if (obs_timeout || bus.result !== er || er !== 16'h0001 || bus.ovf !== eo || eo !== 1'b1 || mem[302] !== er) begin
            errors++; $display("FAIL ovf_result got=%h ovf=%0b mem=%h exp=%h ovf=%0b", bus.result, bus.ovf, mem[302], er, eo);
        end
    endtask

    task automatic test_wrap();
        logic [DW-1:0] er; bit eo;
        int exp_adr[4] = '{1022, 1023, 0, 1};
        mem[1022] = 3; mem[1023] = 4; mem[0] = 5; mem[1] = 6;
        model(0, 1022, 4, er, eo);
        do_op(0, 1022, 4, 600, 0);
        checks++;
        if (obs_timeout || bus.result !== er || er !== 16'd18 || mem[600] !== er || obs_lat != 6) begin
            errors++; $display("FAIL wrap_result got=%0d mem=%0d lat=%0d exp=%0d lat=6", bus.result, mem[600], obs_lat, er);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= adr_q.size() || adr_q[i] != exp_adr[i]) begin
                errors++; $display("FAIL wrap_addr idx=%0d got=%0d exp=%0d", i, (i < adr_q.size()) ? adr_q[i] : -1, exp_adr[i]);
            end
        end
    endtask

    task automatic test_count_zero();
        mem[50] = 16'h1234;
        do_op(0, 700, 0, 50, 0);
        checks++;
        if (obs_timeout || obs_reads != 0 || obs_lat != 2) begin
            errors++; $display("FAIL zero_timing reads=%0d lat=%0d exp=0/2", obs_reads, obs_lat);
        end
        checks++;
        if (mem[50] !== '0 || bus.result !== '0 || bus.ovf !== 1'b0 || obs_writes != 1) begin
            errors++; $display("FAIL zero_result mem=%h result=%h ovf=%0b writes=%0d exp=0/0/0/1", mem[50], bus.result, bus.ovf, obs_writes);
        end
    endtask

    task automatic test_reset_abort();
        for (int i = 0; i < 8; i++) mem[400 + i] = DW'($urandom);
        mem[410] = 16'hBEEF;
        @(negedge clk);
        bus.start = 1; bus.op = 0; bus.base_adr = AW'(400); bus.count = AW'(8); bus.dst_adr = AW'(410);
        @(posedge clk);
        #1 bus.start = 0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.mem_wen} !== 3'b000 || bus.result !== '0) begin
            errors++; $display("FAIL abort_flags got=%b result=%h exp=000 result=0", {bus.busy, bus.done, bus.mem_wen}, bus.result);
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (12) @(negedge clk);
        checks++;
        if (mem[410] !== 16'hBEEF || bus.busy !== 1'b0) begin
            errors++; $display("FAIL abort_dst mem=%h busy=%0b exp=beef/0", mem[410], bus.busy);
        end
    endtask

    task automatic test_ignore_start();
        logic [DW-1:0] er; bit eo;
        for (int i = 0; i < 6; i++) mem[500 + i] = DW'($urandom);
        mem[530] = 16'hCAFE;
        model(0, 500, 6, er, eo);
        do_op(0, 500, 6, 520, 1);
        checks++;
        if (obs_timeout || obs_writes != 1 || obs_wadr !== AW'(520) || bus.result !== er || mem[520] !== er) begin
            errors++; $display("FAIL ignore_result writes=%0d adr=%0d got=%h exp=%h", obs_writes, obs_wadr, bus.result, er);
        end
        checks++;
        if (mem[530] !== 16'hCAFE || obs_busy_after || obs_reads != 6) begin
            errors++; $display("FAIL ignore_side mem530=%h busy_after=%0b reads=%0d exp=cafe/0/6", mem[530], obs_busy_after, obs_reads);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++) begin
            logic [DW-1:0] er; bit eo;
            bit op = 1'($urandom);
            int base = int'($urandom_range(0, DEPTH - 1));
            int cnt  = int'($urandom_range(0, 40));
            int dst  = int'($urandom_range(0, DEPTH - 1));
            model(op, base, cnt, er, eo);
            do_op(op, base, cnt, dst, 0);
            checks++;
            if (obs_timeout || bus.result !== er || bus.ovf !== eo || mem[dst] !== er
                || obs_reads != cnt || obs_lat != cnt + 2 || obs_wdata_bad != 0) begin
                errors++;
                $display("FAIL random_op n=%0d op=%0b got=%h/%0b mem=%h reads=%0d lat=%0d exp=%h/%0b reads=%0d lat=%0d",
                         n, op, bus.result, bus.ovf, mem[dst], obs_reads, obs_lat, er, eo, cnt, cnt + 2);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
        test_reset();
        test_sum_basic();
        test_max_basic();
        test_overflow();
        test_wrap();
        test_count_zero();
        test_reset_abort();
        test_ignore_start();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
